// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a 4-deep byte FIFO that drains into
// an 8N1 UART transmitter.
module uart_tx_arb #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic [2:0] level
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         r_shreg;
  logic [7:0]         w_shreg_nxt;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               r_prio;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [LVL_W-1:0]   r_level;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_full;
  logic               w_push0;
  logic               w_push1;
  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_push_data;
  logic               w_bit_done;

  // Arbitration: prio names the requester that wins a tie.
  assign w_grant0    = req0_valid & (~req1_valid | ~r_prio);
  assign w_grant1    = req1_valid & (~req0_valid |  r_prio);
  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign req0_ready  = w_grant0 & ~w_full & ~rst;
  assign req1_ready  = w_grant1 & ~w_full & ~rst;
  assign w_push0     = req0_valid & req0_ready;
  assign w_push1     = req1_valid & req1_ready;
  assign w_push      = w_push0 | w_push1;
  assign w_push_data = w_push0 ? req0_data : req1_data;

  assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  assign uart_tx = r_tx;
  assign level   = r_level;
  assign busy    = (r_state != S_IDLE) | (r_level != '0);

  // After a grant, priority passes to the requester that was not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_push) begin
      r_prio <= w_push0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Line level is derived from the next state so it changes on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_shreg_nxt = r_mem[r_rptr];
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {1'b0, r_shreg[7:1]};
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a line monitor decodes 8N1 frames and checks
// them against a queue of bytes the stimulus expects to be sent.
module tb_uart_tx_arb;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       uart_tx, busy;
  logic [2:0] level;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx_arb #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_tx(uart_tx), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    starts.delete();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Frame monitor: every bit must hold for CPB cycles; reset aborts the frame.
  initial begin
    logic [9:0] bv;
    logic [7:0] got;
    bit         ok, ab;
    int         n;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        starts.push_back(cyc);
        n  = 0;
        ok = 1'b1;
        ab = 1'b0;
        bv = '0;
        while (n < 10 * CPB && !ab) begin
          if (n > 0) @(negedge clk);
          if (rst) begin
            ab = 1'b1;
          end else begin
            if (n % CPB == 0) bv[n / CPB] = uart_tx;
            else if (uart_tx !== bv[n / CPB]) ok = 1'b0;
            n++;
          end
        end
        if (!ab) begin
          got = bv[8:1];
          check("mon_bit_hold", 32'(ok), 1);
          check("mon_start_bit", 32'(bv[0]), 0);
          check("mon_stop_bit", 32'(bv[9]), 1);
          check("mon_frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("mon_frame_byte", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [7:0] fb [6];
    int         n;
    fb = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    tick(); tick();
    req0_valid = 1'b1; req0_data = 8'hFF;
    #1;
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_uart_tx", 32'(uart_tx), 1);
    check("rst_busy", 32'(busy), 0);
    tick();
    check("rst_no_push", 32'(level), 0);
    req0_valid = 1'b0;
    rst = 1'b0;

    // Single byte 0xA5 with exact latency and duration
    req0_valid = 1'b1; req0_data = 8'hA5;
    #1;
    check("a5_ready0", 32'(req0_ready), 1);
    check("a5_ready1", 32'(req1_ready), 0);
    exp_q.push_back(8'hA5);
    tick();
    req0_valid = 1'b0; req0_data = 8'h00;
    check("a5_level_after_push", 32'(level), 1);
    check("a5_busy_after_push", 32'(busy), 1);
    check("a5_tx_idle_at_e", 32'(uart_tx), 1);
    tick();
    check("a5_tx_start_e1", 32'(uart_tx), 0);
    check("a5_level_after_pop", 32'(level), 0);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("a5_busy_cycles", 32'(n), 40);
    check("a5_level_end", 32'(level), 0);
    check("a5_all_sent", 32'(exp_q.size()), 0);

    // Contention: acceptances alternate starting with requester 0
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      check("cont_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      exp_q.push_back((i % 2 == 0) ? 8'h11 : 8'h22);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_level", 32'(level), 3);
    wait_idle("cont_idle", 250);
    check("cont_all_sent", 32'(exp_q.size()), 0);

    // Full FIFO: no push-through even on the popping edge
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back(fb[i]);
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_data = fb[i];
      #1;
      check("full_ready_fill", 32'(req0_ready), 1);
      tick();
      if (i == 1) check("full_first_pop_e1", 32'(uart_tx), 0);
    end
    check("full_level4", 32'(level), 4);
    req0_data = fb[5];
    #1;
    n = 0;
    while (req0_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("full_ready_low_cycles", 32'(n), 38);
    tick();
    req0_valid = 1'b0; req0_data = 8'h00;
    wait_idle("full_idle", 300);
    check("full_all_sent", 32'(exp_q.size()), 0);
    check("full_frame_count", 32'(starts.size()), 6);
    for (int i = 1; i < starts.size(); i++)
      check("full_frame_gap", 32'(starts[i] - starts[i-1]), 10 * CPB + 1);

    // Reset during DATA bit 3 with two bytes queued
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'h96; tick();
    req0_data = 8'h4B; tick();
    req0_data = 8'hD2; tick();
    req0_valid = 1'b0; req0_data = 8'h00;
    check("rmf_level2", 32'(level), 2);
    for (int i = 0; i < 16; i++) tick();
    check("rmf_tx_bit3", 32'(uart_tx), 0);
    rst = 1'b1;
    tick();
    check("rmf_tx_high", 32'(uart_tx), 1);
    check("rmf_level0", 32'(level), 0);
    check("rmf_busy0", 32'(busy), 0);
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h3C;
    #1;
    check("rmf_ready_new", 32'(req0_ready), 1);
    exp_q.push_back(8'h3C);
    tick();
    req0_valid = 1'b0; req0_data = 8'h00;
    tick();
    check("rmf_new_start", 32'(uart_tx), 0);
    wait_idle("rmf_idle", 200);
    check("rmf_all_sent", 32'(exp_q.size()), 0);

    // Lone requester 1, then priority must have returned to requester 0
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h7E;
    #1;
    check("fair_ready1", 32'(req1_ready), 1);
    check("fair_ready0_idle", 32'(req0_ready), 0);
    exp_q.push_back(8'h7E);
    tick();
    req0_valid = 1'b1; req0_data = 8'h55; req1_data = 8'h66;
    #1;
    check("fair_prio_ready0", 32'(req0_ready), 1);
    check("fair_prio_ready1", 32'(req1_ready), 0);
    exp_q.push_back(8'h55);
    tick();
    req0_valid = 1'b0;
    #1;
    check("fair_ready1_next", 32'(req1_ready), 1);
    exp_q.push_back(8'h66);
    tick();
    req1_valid = 1'b0;
    wait_idle("fair_idle", 250);
    check("fair_all_sent", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
